regfile_mp_sync: RTL and testbench
==================================

// Module: regfile_mp_sync
// PURPOSE
//  Parametrised 2-read/1-write register file for the RISC-V datapath; successor to the fixed 32x32 file.
//  Synchronous registered reads with write-first bypass, optional hardwired-zero entry 0.
//  A post-reset clear sequencer zeroes the array one entry per cycle; `ready` flags completion.
//  Sits between decode (read addresses) and writeback (write port).
// PARAMETERS
//  DATA_W    32  width of each register, in bits
//  ADDR_W     5  address width; DEPTH = 2**ADDR_W entries
//  ZERO_REG   1  1: entry 0 reads as 0 and ignores writes; 0: entry 0 is an ordinary register
// PORTS
//  clk         in   1        clock; all state updates on rising edge
//  rst_n       in   1        asynchronous active-low reset
//  we          in   1        write enable
//  waddr       in   ADDR_W   write address
//  wdata       in   DATA_W   write data
//  re          in   1        read enable; samples raddr1/raddr2
//  raddr1      in   ADDR_W   read address, port 1
//  raddr2      in   ADDR_W   read address, port 2
//  rdata1      out  DATA_W   registered read data, port 1
//  rdata2      out  DATA_W   registered read data, port 2
//  rvalid      out  1        rdata1/rdata2 hold the result of a read accepted last cycle
//  ready       out  1        clear sequence done; write and read ports active
//  parity_err  out  1        present only with REGFILE_PARITY_EN
// BEHAVIOUR
//  - Reset (rst_n=0, async): rdata1=rdata2=0, rvalid=0, ready=0, parity_err=0, clr_cnt=0, state=CLEAR.
//  - FSM CLEAR: each cycle write 0 to mem[clr_cnt], clr_cnt++.
//    After the entry at DEPTH-1 is cleared (DEPTH cycles after reset release), go to READY and set ready=1.
//    In CLEAR: we and re are ignored, rvalid stays 0.
//  - FSM READY: terminal state; only rst_n leaves it. Reset mid-clear or mid-operation restarts CLEAR at entry 0.
//  - Write: when ready && we && !(ZERO_REG && waddr==0), set mem[waddr]=wdata at the rising edge.
//  - Read: when ready && re, at the rising edge set rdataN to the value of mem[raddrN]; rvalid=1 next cycle.
//    Latency is 1 cycle.
//  - When re=0: rdataN hold their value; rvalid=0 next cycle.
//  - Bypass (write-first): same-edge we && re with waddr==raddrN (write not suppressed) -> rdataN=wdata.
//    Both ports bypass independently; raddr1==raddr2 is legal.
//  - ZERO_REG=1: a read of address 0 returns 0 always, including the bypass case.
//  - Full-range addressing only; there are no out-of-range addresses (DEPTH=2**ADDR_W).
// CONFIGURATION
//  REGFILE_PARITY_EN defined:
//    - each entry stores an extra even-parity bit, computed on write (clear writes parity 0).
//    - on each accepted read, parity of each port is checked.
//      parity_err is registered with rdata and is 1 if either port mismatches.
//    - parity_err is valid only when rvalid=1; otherwise it is 0.
//  REGFILE_PARITY_EN undefined: no parity storage, no parity_err port.
//    Array is DEPTH x DATA_W; behaviour is otherwise identical.
// TESTING
//  1. Release rst_n -> ready=0 for exactly 32 cycles, then 1; read all 32 entries -> all 0.
//  2. Write 0xDEADBEEF to x5; read x5 next cycle -> rdata1=0xDEADBEEF one cycle after re, with rvalid=1.
//  3. Same edge: write 0x12345678 to x7 and read raddr1=raddr2=7 -> both ports return 0x12345678 (bypass).
//  4. ZERO_REG=1: write 0xFFFFFFFF to x0, then read x0 -> 0; same-edge bypass on x0 -> 0.
//  5. Write x3=0xA5A5A5A5; assert rst_n=0 mid-clear and again when ready -> outputs 0 at once.
//     Full DEPTH-cycle clear repeats; x3 reads 0 afterwards.
//  6. With REGFILE_PARITY_EN: force a flip of one stored bit in x9, read x9 -> parity_err=1 with rvalid=1.
//     Read x10 -> parity_err=0.

Source files
------------

// File: rtl/regfile_mp_sync.sv
// 2-read/1-write register file: registered reads, write-first bypass, optional zero entry 0,
// post-reset clear sequencer. Define REGFILE_PARITY_EN to add per-entry parity and parity_err.
module regfile_mp_sync #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              rvalid,
  output logic              ready
`ifdef REGFILE_PARITY_EN
  , output logic            parity_err
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  // state    | meaning
  // ST_CLEAR | zero mem[clr_cnt] each cycle; we/re ignored
  // ST_READY | normal operation; left only through rst_n
  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_user;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              zero1, zero2;
  logic              byp1, byp2;
  logic [DATA_W-1:0] rd_next1, rd_next2;

  always_comb begin
    wr_user   = ready && we && !((ZERO_REG != 0) && (waddr == '0));
    mem_we    = (state == ST_CLEAR) || wr_user;
    mem_waddr = (state == ST_CLEAR) ? clr_cnt : waddr;
    mem_wdata = (state == ST_CLEAR) ? '0 : wdata;

    zero1 = (ZERO_REG != 0) && (raddr1 == '0);
    zero2 = (ZERO_REG != 0) && (raddr2 == '0);
    byp1  = wr_user && (waddr == raddr1);
    byp2  = wr_user && (waddr == raddr2);

    rd_next1 = zero1 ? '0 : (byp1 ? wdata : mem[raddr1]);
    rd_next2 = zero2 ? '0 : (byp2 ? wdata : mem[raddr2]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (&clr_cnt) begin
            state <= ST_READY;
            ready <= 1'b1;
          end
        end
        default: begin
          state <= ST_READY;
          ready <= 1'b1;
        end
      endcase
    end
  end

  // Array itself is not reset; the clear sequence zeroes it after reset release.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

`ifdef REGFILE_PARITY_EN
  logic mem_par [DEPTH];
  logic perr1, perr2;

  always_ff @(posedge clk) begin
    if (mem_we) mem_par[mem_waddr] <= ^mem_wdata;
  end

  // Bypassed and hardwired-zero reads never touch the stored word, so they cannot mismatch.
  always_comb begin
    perr1 = !zero1 && !byp1 && ((^mem[raddr1]) != mem_par[raddr1]);
    perr2 = !zero2 && !byp2 && ((^mem[raddr2]) != mem_par[raddr2]);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata1     <= '0;
      rdata2     <= '0;
      rvalid     <= 1'b0;
`ifdef REGFILE_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      rvalid <= ready && re;
      if (ready && re) begin
        rdata1 <= rd_next1;
        rdata2 <= rd_next2;
      end
`ifdef REGFILE_PARITY_EN
      parity_err <= ready && re && (perr1 || perr2);
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp_sync.sv
// Randomized self-checking bench for regfile_mp_sync against an array-based reference model.
// Define REGFILE_PARITY_EN to also exercise the parity checker.
module tb_regfile_mp_sync;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int ZR    = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic          re = 1'b0;
  logic [AW-1:0] raddr1 = '0;
  logic [AW-1:0] raddr2 = '0;
  logic [DW-1:0] rdata1, rdata2;
  logic          rvalid, ready;
`ifdef REGFILE_PARITY_EN
  logic          parity_err;
`endif

  regfile_mp_sync #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(ZR)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2), .rvalid(rvalid), .ready(ready)
`ifdef REGFILE_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_err = 0;
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp1 = '0;
  logic [DW-1:0] exp2 = '0;
  int            bad_addr = -1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a, input logic w,
                                             input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    if (ZR != 0 && a == 0) return '0;
    if (w && wa == a) return wd;
    return model[a];
  endfunction

  // One clocked access: drive at negedge, compare at the following negedge.
  task automatic op(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                    input logic r, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                    input string tag);
    logic exp_perr;
    exp_perr = 1'b0;
    we = w; waddr = wa; wdata = wd; re = r; raddr1 = a1; raddr2 = a2;
    if (r) begin
      exp1 = ref_read(a1, w, wa, wd);
      exp2 = ref_read(a2, w, wa, wd);
      exp_perr = (int'(a1) == bad_addr && !(w && wa == a1)) ||
                 (int'(a2) == bad_addr && !(w && wa == a2));
    end
    if (w && !(ZR != 0 && wa == 0)) begin
      model[wa] = wd;
      if (int'(wa) == bad_addr) bad_addr = -1;
    end
    @(posedge clk);
    @(negedge clk);
    check({tag, ".rdata1"}, 64'(rdata1), 64'(exp1));
    check({tag, ".rdata2"}, 64'(rdata2), 64'(exp2));
    check({tag, ".rvalid"}, 64'(rvalid), 64'(r));
`ifdef REGFILE_PARITY_EN
    check({tag, ".parity_err"}, 64'(parity_err), 64'(exp_perr));
`endif
    we = 1'b0; re = 1'b0;
  endtask

  task automatic assert_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    we = 1'b0; re = 1'b0;
    #1;
    check({tag, ".rdata1"}, 64'(rdata1), 64'h0);
    check({tag, ".rdata2"}, 64'(rdata2), 64'h0);
    check({tag, ".rvalid"}, 64'(rvalid), 64'h0);
    check({tag, ".ready"}, 64'(ready), 64'h0);
`ifdef REGFILE_PARITY_EN
    check({tag, ".parity_err"}, 64'(parity_err), 64'h0);
`endif
    exp1 = '0; exp2 = '0;
    @(posedge clk);
    @(posedge clk);
  endtask

  // Release reset and run the clear sequence with junk on the ports; abort_at>0 stops early.
  task automatic release_and_clear(input int abort_at);
    int edges;
    edges = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH + 8; i++) begin
      we = 1'b1; re = 1'b1;
      waddr = AW'($urandom_range(0, DEPTH - 1));
      wdata = $urandom;
      raddr1 = AW'($urandom_range(0, DEPTH - 1));
      raddr2 = AW'($urandom_range(0, DEPTH - 1));
      @(posedge clk);
      @(negedge clk);
      edges++;
      if (abort_at > 0 && edges == abort_at) break;
      if (ready) break;
      check("clear.rvalid", 64'(rvalid), 64'h0);
    end
    we = 1'b0; re = 1'b0;
    if (abort_at == 0) begin
      check("clear.len", 64'(edges), 64'(DEPTH));
      check("clear.rdata1", 64'(rdata1), 64'h0);
      for (int k = 0; k < DEPTH; k++) model[k] = '0;
      bad_addr = -1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < DEPTH; k++) model[k] = '0;
    #3;
    check("rst.rdata1", 64'(rdata1), 64'h0);
    check("rst.rdata2", 64'(rdata2), 64'h0);
    check("rst.rvalid", 64'(rvalid), 64'h0);
    check("rst.ready", 64'(ready), 64'h0);
    release_and_clear(0);

    for (int i = 0; i < DEPTH; i++)
      op(1'b0, '0, '0, 1'b1, AW'(i), AW'(DEPTH - 1 - i), "init_read");

    op(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, "wr_x5");
    op(1'b0, '0, '0, 1'b1, 5'd5, 5'd6, "rd_x5");
    op(1'b0, '0, '0, 1'b0, 5'd1, 5'd2, "hold");
    op(1'b1, 5'd7, 32'h12345678, 1'b1, 5'd7, 5'd7, "bypass_x7");
    op(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, '0, '0, "wr_x0");
    op(1'b0, '0, '0, 1'b1, 5'd0, 5'd7, "rd_x0");
    op(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, "bypass_x0");
    op(1'b1, 5'd31, 32'hCAFEF00D, 1'b1, 5'd31, 5'd30, "bypass_x31");

    for (int i = 0; i < 400; i++) begin
      logic          w, r;
      logic [AW-1:0] wa, a1, a2;
      logic [DW-1:0] wd;
      w  = 1'($urandom_range(0, 1));
      r  = ($urandom_range(0, 3) != 0);
      wa = AW'($urandom_range(0, DEPTH - 1));
      wd = $urandom;
      a1 = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
      a2 = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
      op(w, wa, wd, r, a1, a2, "rand");
    end

    op(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, '0, '0, "wr_x3");
    op(1'b0, '0, '0, 1'b1, 5'd3, 5'd3, "rd_x3");
    assert_reset("rst_op");
    release_and_clear(10);
    assert_reset("rst_clr");
    release_and_clear(0);
    op(1'b0, '0, '0, 1'b1, 5'd3, 5'd5, "rd_x3_after");

`ifdef REGFILE_PARITY_EN
    op(1'b1, 5'd9, 32'h0F0F1234, 1'b0, '0, '0, "wr_x9");
    op(1'b1, 5'd10, 32'h89ABCDEF, 1'b0, '0, '0, "wr_x10");
    dut.mem[9][4] = ~dut.mem[9][4];
    model[9][4] = ~model[9][4];
    bad_addr = 9;
    op(1'b0, '0, '0, 1'b1, 5'd9, 5'd10, "par_x9");
    op(1'b0, '0, '0, 1'b1, 5'd10, 5'd10, "par_x10");
    op(1'b0, '0, '0, 1'b1, 5'd10, 5'd9, "par_x9_p2");
    op(1'b1, 5'd9, 32'h11111111, 1'b1, 5'd9, 5'd9, "par_fix");
    op(1'b0, '0, '0, 1'b1, 5'd9, 5'd9, "par_clean");
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
